skew_feeder_4: RTL and testbench



---
 rtl/skew_feeder_4_if.sv | 27 ++
 rtl/skew_feeder_4.sv | 191 +++++++++++++++++++
 tb/tb_skew_feeder_4.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skew_feeder_4_if.sv
// skew_feeder_4_if: operand-side and shifter-side handshake bundle for skew_feeder_4.
// The slave modport is the feeder's view; the master modport is the surrounding logic's view.
interface skew_feeder_4_if #(
    parameter int HIGHT      = 4,
    parameter int DATA_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [HIGHT*DATA_WIDTH-1:0]   in_data;
    logic                          in_last;
    logic                          out_ready;
    logic                          out_enable;
    logic [HIGHT*DATA_WIDTH-1:0]   out_data;
    logic                          out_first;
    logic                          done;
    logic                          busy;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_enable, out_data, out_first, done, busy
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_enable, out_data, out_first, done, busy
    );
endinterface

// File: rtl/skew_feeder_4.sv
// skew_feeder_4: buffers lane-parallel operand vectors in a small FIFO, issues them to the
// triangle skew shifter, then injects HIGHT-1 zero vectors per tile so every lane drains.
// Optional build macro: SKEW_FEEDER_PERF_EN adds stall_cycles and tile_count outputs.
module skew_feeder_4 #(
    parameter int HIGHT      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    skew_feeder_4_if.slave bus
`ifdef SKEW_FEEDER_PERF_EN
    ,
    output logic [31:0]    stall_cycles,
    output logic [31:0]    tile_count
`endif
);
    localparam int VEC_W = HIGHT * DATA_WIDTH;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int FCW   = $clog2(HIGHT + 1);

    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]  CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1);
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(HIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Storage entry is {last, data}; data is never reset, only the control around it.
    logic [VEC_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [VEC_W:0]   head;
    logic             head_last;
    logic [VEC_W-1:0] head_data;

    state_t           state;
    state_t           state_nxt;
    logic [FCW-1:0]   flush_cnt;
    logic [FCW-1:0]   flush_nxt;
    logic             first_flag;
    logic             first_nxt;
    logic             done_nxt;
    logic             done_p1;
    logic             enable;
    logic             first_beat;
    logic [VEC_W-1:0] out_data_c;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_last = head[VEC_W];
    assign head_data = head[VEC_W-1:0];

    // No pass-through: a full FIFO refuses input even in a cycle that also pops.
    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;

    assign bus.out_enable = enable;
    assign bus.out_data   = out_data_c;
    assign bus.out_first  = first_beat;
    assign bus.done       = done_p1 && rst_n;
    assign bus.busy       = (state != IDLE) || !empty;

    // FIFO write port: capture {last, data} on every accepted vector.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    // Control registers: FIFO pointers/occupancy, FSM state, flush counter, first flag, done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            flush_cnt  <= '0;
            first_flag <= 1'b1;
            done_p1    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            state      <= state_nxt;
            flush_cnt  <= flush_nxt;
            first_flag <= first_nxt;
            done_p1    <= done_nxt;
        end
    end

    // Sequencer: issue FIFO vectors, then HIGHT-1 zero beats, holding everything while out_ready=0.
    always_comb begin
        state_nxt  = state;
        flush_nxt  = flush_cnt;
        first_nxt  = first_flag;
        done_nxt   = 1'b0;
        enable     = 1'b0;
        pop        = 1'b0;
        first_beat = 1'b0;
        out_data_c = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    // The transition cycle never issues a beat.
                    if (!empty) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    // An empty FIFO mid-tile is a bubble: the shifter holds, so skew survives.
                    if (bus.out_ready && !empty) begin
                        enable     = 1'b1;
                        pop        = 1'b1;
                        out_data_c = head_data;
                        if (first_flag) begin
                            first_beat = 1'b1;
                            first_nxt  = 1'b0;
                        end
                        if (head_last) begin
                            if (HIGHT == 1) begin
                                done_nxt  = 1'b1;
                                first_nxt = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                flush_nxt = FLUSH_INIT;
                                state_nxt = FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (bus.out_ready) begin
                        enable    = 1'b1;
                        flush_nxt = flush_cnt - FLUSH_ONE;
                        if (flush_cnt == FLUSH_ONE) begin
                            done_nxt  = 1'b1;
                            first_nxt = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef SKEW_FEEDER_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters: non-idle cycles without a beat (saturating) and completed tiles (wrapping).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            tile_count   <= '0;
        end else begin
            if ((state != IDLE) && !enable) begin
                stall_cycles <= sat_inc32(stall_cycles);
            end
            if (done_p1) begin
                tile_count <= tile_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_skew_feeder_4.sv
// tb_skew_feeder_4: directed scenarios for skew_feeder_4 with hand-derived beat schedules.
// A monitor logs every enabled beat and done pulse; each test task checks the log inline.
module tb_skew_feeder_4;
    localparam int HIGHT = 4;
    localparam int DW    = 16;
    localparam int FD    = 8;
    localparam int VW    = HIGHT * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    skew_feeder_4_if #(.HIGHT(HIGHT), .DATA_WIDTH(DW)) bus ();

`ifdef SKEW_FEEDER_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] tile_count;
`endif

    skew_feeder_4 #(
        .HIGHT(HIGHT),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef SKEW_FEEDER_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .tile_count(tile_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stale = 0;
    logic [VW-1:0] beat_data[$];
    logic          beat_first[$];
    int            beat_cyc[$];
    int            done_cyc[$];

    // Vector k: lane i carries k + 0x100*i so lane swaps are visible.
    function automatic logic [VW-1:0] mkvec(input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < HIGHT; i++) v[DW*i +: DW] = DW'(k + 256 * i);
        return v;
    endfunction

    // Cycle counter bumps at each negedge; outputs are sampled 2 time units later.
    always @(negedge clk) begin
        cyc = cyc + 1;
        #2;
        if (bus.out_enable === 1'b1) begin
            beat_data.push_back(bus.out_data);
            beat_first.push_back(bus.out_first);
            beat_cyc.push_back(cyc);
        end else if (bus.out_data !== '0 || bus.out_first !== 1'b0) begin
            stale = stale + 1;
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic clear_log();
        beat_data.delete();
        beat_first.delete();
        beat_cyc.delete();
        done_cyc.delete();
        stale = 0;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = mkvec(9);
        bus.in_last  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.out_enable !== 1'b0) begin fails++; $display("FAIL reset_out_enable: got %b want 0", bus.out_enable); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        tests++; if (bus.out_first !== 1'b0) begin fails++; $display("FAIL reset_out_first: got %b want 0", bus.out_first); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL release_busy: got %b want 0", bus.busy); end
        tests++; if (bus.out_enable !== 1'b0) begin fails++; $display("FAIL release_out_enable: got %b want 0", bus.out_enable); end
    endtask

    task automatic test_single_tile();
        int s0 = 0;
        int miss = 0;
        logic [VW-1:0] exp_d;
        clear_log();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (c < 4) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(c + 1); bus.in_last = (c == 3);
            end else idle_inputs();
            #1;
            if (c == 0) s0 = cyc;
            if (bus.in_valid && !bus.in_ready) miss++;
        end
        #4;
        tests++; if (miss !== 0) begin fails++; $display("FAIL single_push_refused: got %0d want 0", miss); end
        tests++; if (beat_cyc.size() !== 7) begin fails++; $display("FAIL single_beat_count: got %0d want 7", beat_cyc.size()); end
        for (int b = 0; b < beat_cyc.size() && b < 7; b++) begin
            exp_d = (b < 4) ? mkvec(b + 1) : '0;
            tests++; if (beat_data[b] !== exp_d) begin fails++; $display("FAIL single_data[%0d]: got %h want %h", b, beat_data[b], exp_d); end
            tests++; if (beat_first[b] !== (b == 0)) begin fails++; $display("FAIL single_first[%0d]: got %b want %b", b, beat_first[b], (b == 0)); end
            tests++; if (beat_cyc[b] !== s0 + 2 + b) begin fails++; $display("FAIL single_cycle[%0d]: got %0d want %0d", b, beat_cyc[b] - s0, 2 + b); end
        end
        tests++; if (done_cyc.size() !== 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", done_cyc.size()); end
        tests++; if ((done_cyc.size() > 0 ? done_cyc[0] - s0 : -1) !== 9) begin fails++; $display("FAIL single_done_cycle: got %0d want 9", (done_cyc.size() > 0 ? done_cyc[0] - s0 : -1)); end
        tests++; if (stale !== 0) begin fails++; $display("FAIL single_stale_bus: got %0d want 0", stale); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int s0 = 0;
        int in_stall = 0;
        logic [VW-1:0] exp_d;
        pulse_reset();
        clear_log();
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 2 && c <= 4);
            if (c < 4) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(c + 1); bus.in_last = (c == 3);
            end else idle_inputs();
            #1;
            if (c == 0) s0 = cyc;
        end
        #4;
        foreach (beat_cyc[b]) if (beat_cyc[b] >= s0 + 2 && beat_cyc[b] <= s0 + 4) in_stall++;
        tests++; if (in_stall !== 0) begin fails++; $display("FAIL bp_beat_during_stall: got %0d want 0", in_stall); end
        tests++; if (beat_cyc.size() !== 7) begin fails++; $display("FAIL bp_beat_count: got %0d want 7", beat_cyc.size()); end
        for (int b = 0; b < beat_cyc.size() && b < 7; b++) begin
            exp_d = (b < 4) ? mkvec(b + 1) : '0;
            tests++; if (beat_data[b] !== exp_d) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", b, beat_data[b], exp_d); end
            tests++; if (beat_cyc[b] !== s0 + 5 + b) begin fails++; $display("FAIL bp_cycle[%0d]: got %0d want %0d", b, beat_cyc[b] - s0, 5 + b); end
        end
        tests++; if ((done_cyc.size() == 1 ? done_cyc[0] - s0 : -1) !== 12) begin fails++; $display("FAIL bp_done_cycle: got %0d want 12", (done_cyc.size() == 1 ? done_cyc[0] - s0 : -1)); end
`ifdef SKEW_FEEDER_PERF_EN
        tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL perf_stall_cycles: got %0d want 3", stall_cycles); end
        tests++; if (tile_count !== 32'd1) begin fails++; $display("FAIL perf_tile_count: got %0d want 1", tile_count); end
`endif
    endtask

    task automatic test_fifo_full();
        int s0 = 0;
        int k = 1;
        int acc9 = -1;
        logic [VW-1:0] exp_d;
        clear_log();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 12);
            if (k <= 9) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(k); bus.in_last = (k == 9);
            end else idle_inputs();
            #1;
            if (c == 0) s0 = cyc;
            if (c == 10) begin
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
                tests++; if (k !== 9) begin fails++; $display("FAIL full_accepted: got %0d want 8", k - 1); end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (k == 9) acc9 = cyc;
                k++;
            end
        end
        #4;
        tests++; if (beat_cyc.size() !== 12) begin fails++; $display("FAIL full_beat_count: got %0d want 12", beat_cyc.size()); end
        tests++; if ((beat_cyc.size() > 0 ? beat_cyc[0] - s0 : -1) !== 12) begin fails++; $display("FAIL full_first_beat_cycle: got %0d want 12", (beat_cyc.size() > 0 ? beat_cyc[0] - s0 : -1)); end
        tests++; if (acc9 - s0 !== 13) begin fails++; $display("FAIL full_ninth_accept: got %0d want 13", acc9 - s0); end
        for (int b = 0; b < beat_cyc.size() && b < 12; b++) begin
            exp_d = (b < 9) ? mkvec(b + 1) : '0;
            tests++; if (beat_data[b] !== exp_d) begin fails++; $display("FAIL full_data[%0d]: got %h want %h", b, beat_data[b], exp_d); end
        end
        tests++; if ((done_cyc.size() == 1 ? done_cyc[0] - s0 : -1) !== 24) begin fails++; $display("FAIL full_done_cycle: got %0d want 24", (done_cyc.size() == 1 ? done_cyc[0] - s0 : -1)); end
    endtask

    task automatic test_back_to_back();
        int s0 = 0;
        int miss = 0;
        int exp_k[12] = '{1, 2, 3, 4, 0, 0, 0, 5, 6, 0, 0, 0};
        int exp_c[12] = '{2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14};
        logic [VW-1:0] exp_d;
        clear_log();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (c < 4) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(c + 1); bus.in_last = (c == 3);
            end else if (c == 6 || c == 7) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(c - 1); bus.in_last = (c == 7);
            end else idle_inputs();
            #1;
            if (c == 0) s0 = cyc;
            if (bus.in_valid && !bus.in_ready) miss++;
        end
        #4;
        tests++; if (miss !== 0) begin fails++; $display("FAIL b2b_push_refused: got %0d want 0", miss); end
        tests++; if (beat_cyc.size() !== 12) begin fails++; $display("FAIL b2b_beat_count: got %0d want 12", beat_cyc.size()); end
        for (int b = 0; b < beat_cyc.size() && b < 12; b++) begin
            exp_d = (exp_k[b] == 0) ? '0 : mkvec(exp_k[b]);
            tests++; if (beat_data[b] !== exp_d) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", b, beat_data[b], exp_d); end
            tests++; if (beat_first[b] !== (b == 0 || b == 7)) begin fails++; $display("FAIL b2b_first[%0d]: got %b want %b", b, beat_first[b], (b == 0 || b == 7)); end
            tests++; if (beat_cyc[b] - s0 !== exp_c[b]) begin fails++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", b, beat_cyc[b] - s0, exp_c[b]); end
        end
        tests++; if (done_cyc.size() !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", done_cyc.size()); end
        tests++; if ((done_cyc.size() > 0 ? done_cyc[0] - s0 : -1) !== 9) begin fails++; $display("FAIL b2b_done_a: got %0d want 9", (done_cyc.size() > 0 ? done_cyc[0] - s0 : -1)); end
        tests++; if ((done_cyc.size() > 1 ? done_cyc[1] - s0 : -1) !== 15) begin fails++; $display("FAIL b2b_done_b: got %0d want 15", (done_cyc.size() > 1 ? done_cyc[1] - s0 : -1)); end
    endtask

    task automatic test_reset_flush();
        int s0 = 0;
        clear_log();
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            rst_n = (c != 7);
            if (c < 4) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(c + 1); bus.in_last = (c == 3);
            end else if (c == 6) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(7); bus.in_last = 1'b0;
            end else if (c == 9) begin
                bus.in_valid = 1'b1; bus.in_data = mkvec(8); bus.in_last = 1'b1;
            end else idle_inputs();
            #1;
            if (c == 0) s0 = cyc;
            if (c == 7) begin
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rstf_in_ready_low: got %b want 0", bus.in_ready); end
                tests++; if (bus.out_enable !== 1'b0) begin fails++; $display("FAIL rstf_enable_in_reset: got %b want 0", bus.out_enable); end
            end
            if (c == 8) begin
                tests++; if (bus.out_enable !== 1'b0) begin fails++; $display("FAIL rstf_out_enable: got %b want 0", bus.out_enable); end
                tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstf_busy: got %b want 0", bus.busy); end
                tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstf_in_ready: got %b want 1", bus.in_ready); end
            end
        end
        #4;
        tests++; if (beat_cyc.size() !== 9) begin fails++; $display("FAIL rstf_beat_count: got %0d want 9", beat_cyc.size()); end
        tests++; if ((beat_cyc.size() > 5 ? beat_cyc[5] - s0 : -1) !== 11) begin fails++; $display("FAIL rstf_new_tile_cycle: got %0d want 11", (beat_cyc.size() > 5 ? beat_cyc[5] - s0 : -1)); end
        tests++; if ((beat_data.size() > 5 ? beat_data[5] : '0) !== mkvec(8)) begin fails++; $display("FAIL rstf_new_tile_data: got %h want %h", (beat_data.size() > 5 ? beat_data[5] : '0), mkvec(8)); end
        tests++; if ((beat_first.size() > 5 ? beat_first[5] : 1'b0) !== 1'b1) begin fails++; $display("FAIL rstf_new_tile_first: got %b want 1", (beat_first.size() > 5 ? beat_first[5] : 1'b0)); end
        tests++; if (done_cyc.size() !== 1) begin fails++; $display("FAIL rstf_done_count: got %0d want 1", done_cyc.size()); end
        tests++; if ((done_cyc.size() > 0 ? done_cyc[0] - s0 : -1) !== 15) begin fails++; $display("FAIL rstf_done_cycle: got %0d want 15", (done_cyc.size() > 0 ? done_cyc[0] - s0 : -1)); end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        test_reset();
        test_single_tile();
        test_backpressure();
        test_fifo_full();
        test_back_to_back();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
